// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory port arbiter.
// Imported by the arbiter top and its burst sequencer.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_RELEASE,
    ST_WRITE
  } state_t;

  typedef enum logic {
    CL_ICACHE = 1'b0,
    CL_DCACHE = 1'b1
  } client_t;

  localparam int DEF_LINEWORDS = 4;
  localparam int DEF_DATABITS  = 32;
  localparam int WORD_STEP     = DEF_DATABITS / 8;

  function automatic int word_step(input int databits);
    return databits / 8;
  endfunction

endpackage

// File: rtl/mem_burst_seq.sv
// Burst issue/return counters and base+offset word address generator.
// Loading a new base clears both counters.
module mem_burst_seq
  import mem_arb_pkg::*;
#(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = DEF_DATABITS,
  parameter int LINEWORDS = DEF_LINEWORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [ADDRBITS-1:0] i_base,
  input  logic                i_issue,
  input  logic                i_ret,
  output logic [ADDRBITS-1:0] o_addr,
  output logic                o_issue_zero,
  output logic                o_issue_last,
  output logic                o_ret_last,
  output logic                o_ret_full
);

  localparam int CW = $clog2(LINEWORDS) + 1;
  localparam logic [ADDRBITS-1:0] STEP =
    ADDRBITS'(word_step(DATABITS));

  logic [ADDRBITS-1:0] r_base;
  logic [CW-1:0]       r_issue;
  logic [CW-1:0]       r_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_issue <= '0;
      r_ret   <= '0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_issue <= '0;
      r_ret   <= '0;
    end else begin
      if (i_issue) r_issue <= r_issue + CW'(1);
      if (i_ret)   r_ret   <= r_ret + CW'(1);
    end
  end

  // Sum wraps naturally at ADDRBITS.
  assign o_addr       = r_base + ADDRBITS'(r_issue) * STEP;
  assign o_issue_zero = (r_issue == '0);
  assign o_issue_last = (r_issue == CW'(LINEWORDS - 1));
  assign o_ret_last   = (r_ret == CW'(LINEWORDS - 1));
  assign o_ret_full   = (r_ret == CW'(LINEWORDS));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between
// icache line fills and dcache fill/write-back bursts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = DEF_DATABITS,
  parameter int LINEWORDS = DEF_LINEWORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                icache_fill_req,
  input  logic [ADDRBITS-1:0] icache_fill_addr,
  output logic [DATABITS-1:0] icache_fill_data,
  output logic                icache_fill_valid,
  output logic                icache_fill_done,
  input  logic                dcache_req,
  input  logic                dcache_we,
  input  logic [ADDRBITS-1:0] dcache_addr,
  input  logic [DATABITS-1:0] dcache_wdata,
  output logic                dcache_wdata_ack,
  output logic [DATABITS-1:0] dcache_rdata,
  output logic                dcache_rdata_valid,
  output logic                dcache_done,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  output logic                mem_wrreq,
  output logic                mem_rdreq,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_out_valid
);

  state_t  r_state;
  client_t r_client;
  client_t r_last;

  logic                w_any;
  logic                w_gnt_d;
  logic                w_load;
  logic                w_rd_issue;
  logic                w_write;
  logic                w_accept;
  logic                w_to_i;
  logic                w_to_d;
  logic                w_done_rd;
  logic [ADDRBITS-1:0] w_addr;
  logic [ADDRBITS-1:0] w_base;
  logic                w_issue_zero;
  logic                w_issue_last;
  logic                w_ret_last;
  logic                w_ret_full;

  // Both requesting: whoever was not served last wins.
  assign w_any   = icache_fill_req | dcache_req;
  assign w_gnt_d = dcache_req &
                   (~icache_fill_req | (r_last == CL_ICACHE));
  assign w_load  = (r_state == ST_IDLE) & w_any;
  assign w_base  = w_gnt_d ? dcache_addr : icache_fill_addr;

  assign w_rd_issue = (r_state == ST_RD_ISSUE);
  assign w_write    = (r_state == ST_WRITE);

  // The first issue cycle cannot carry a return word.
  assign w_accept = mem_out_valid & ~w_ret_full &
                    ((w_rd_issue & ~w_issue_zero) |
                     (r_state == ST_RD_DRAIN));
  assign w_done_rd = w_accept & w_ret_last;
  assign w_to_i    = w_accept & (r_client == CL_ICACHE);
  assign w_to_d    = w_accept & (r_client == CL_DCACHE);

  mem_burst_seq #(
    .ADDRBITS (ADDRBITS),
    .DATABITS (DATABITS),
    .LINEWORDS(LINEWORDS)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_base      (w_base),
    .i_issue     (w_rd_issue | w_write),
    .i_ret       (w_accept),
    .o_addr      (w_addr),
    .o_issue_zero(w_issue_zero),
    .o_issue_last(w_issue_last),
    .o_ret_last  (w_ret_last),
    .o_ret_full  (w_ret_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_client <= CL_DCACHE;
      r_last   <= CL_ICACHE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_client <= w_gnt_d ? CL_DCACHE : CL_ICACHE;
            r_last   <= w_gnt_d ? CL_DCACHE : CL_ICACHE;
            r_state  <= (w_gnt_d & dcache_we) ?
                        ST_WRITE : ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          if (w_done_rd)         r_state <= ST_RELEASE;
          else if (w_issue_last) r_state <= ST_RD_DRAIN;
        end
        ST_RD_DRAIN: begin
          if (w_done_rd) r_state <= ST_RELEASE;
        end
        ST_WRITE: begin
          if (w_issue_last) r_state <= ST_RELEASE;
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_rdreq = w_rd_issue;
  assign mem_wrreq = w_write;
  assign mem_addr  = (w_rd_issue | w_write) ? w_addr : '0;
  assign mem_in    = w_write ? dcache_wdata : '0;

  assign icache_fill_valid = w_to_i;
  assign icache_fill_data  = w_to_i ? mem_out : '0;
  assign icache_fill_done  = w_to_i & w_ret_last;

  assign dcache_wdata_ack   = w_write;
  assign dcache_rdata_valid = w_to_d;
  assign dcache_rdata       = w_to_d ? mem_out : '0;
  assign dcache_done        = (w_to_d & w_ret_last) |
                              (w_write & w_issue_last);

endmodule
